// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the RV32IM execute stage.
//   - XLEN_DEF      : default datapath width
//   - FS_*          : function-select codes carried in fs_in
//   - FWD_*         : operand forwarding-select encodings
//   - div_state_e   : iterative divider FSM states
//   - is_div_op()   : true for the four multi-cycle divide/remainder codes
package ex_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [3:0] FS_ADD  = 4'd0;
    localparam logic [3:0] FS_SUB  = 4'd1;
    localparam logic [3:0] FS_SLL  = 4'd2;
    localparam logic [3:0] FS_SLT  = 4'd3;
    localparam logic [3:0] FS_SLTU = 4'd4;
    localparam logic [3:0] FS_XOR  = 4'd5;
    localparam logic [3:0] FS_SRL  = 4'd6;
    localparam logic [3:0] FS_SRA  = 4'd7;
    localparam logic [3:0] FS_OR   = 4'd8;
    localparam logic [3:0] FS_AND  = 4'd9;
    localparam logic [3:0] FS_MUL  = 4'd10;
    localparam logic [3:0] FS_MULH = 4'd11;
    localparam logic [3:0] FS_DIV  = 4'd12;
    localparam logic [3:0] FS_DIVU = 4'd13;
    localparam logic [3:0] FS_REM  = 4'd14;
    localparam logic [3:0] FS_REMU = 4'd15;

    // Code 3 is reserved and falls back to the ID/EX operand.
    localparam logic [1:0] FWD_ID  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic is_div_op(input logic [3:0] fs);
        return (fs == FS_DIV) || (fs == FS_DIVU) || (fs == FS_REM) || (fs == FS_REMU);
    endfunction

endpackage

// File: rtl/div_iter.sv
// div_iter: iterative restoring divider, one quotient bit per cycle.
//   clk, reset            : clock, synchronous active-high reset
//   start                 : latch operands (honoured only in IDLE)
//   flush                 : abandon any divide, return to IDLE
//   is_signed, is_rem     : signed operation / return remainder instead of quotient
//   dividend, divisor     : operands, sampled on start
//   busy                  : iterations in progress
//   done                  : result valid this cycle (DONE state)
//   result                : sign-corrected quotient or remainder
module div_iter
    import ex_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int DIV_ITERS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic            is_signed,
    input  logic            is_rem,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(DIV_ITERS) + 1;

    div_state_e       state_r;
    logic [CNT_W-1:0] count_r;
    logic [XLEN-1:0]  q_r;
    logic [XLEN-1:0]  r_r;
    logic [XLEN-1:0]  d_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic             rem_r;

    logic             sign_a_s;
    logic             sign_b_s;
    logic [XLEN-1:0]  mag_a_s;
    logic [XLEN-1:0]  mag_b_s;
    logic [XLEN:0]    trial_s;
    logic [XLEN-1:0]  q_next_s;
    logic [XLEN-1:0]  r_next_s;
    logic [XLEN-1:0]  q_fix_s;
    logic [XLEN-1:0]  r_fix_s;

    // Operand magnitudes for the unsigned core.
    always_comb begin
        sign_a_s = is_signed & dividend[XLEN-1];
        sign_b_s = is_signed & divisor[XLEN-1];
        mag_a_s  = sign_a_s ? (~dividend + {{(XLEN-1){1'b0}}, 1'b1}) : dividend;
        mag_b_s  = sign_b_s ? (~divisor  + {{(XLEN-1){1'b0}}, 1'b1}) : divisor;
    end

    // One restoring step: shift the next dividend bit into the partial remainder.
    // With a zero divisor every step subtracts nothing, so the quotient fills with
    // ones and the remainder ends up equal to the dividend magnitude.
    always_comb begin
        trial_s = {r_r, q_r[XLEN-1]};
        if (trial_s >= {1'b0, d_r}) begin
            r_next_s = trial_s[XLEN-1:0] - d_r;
            q_next_s = {q_r[XLEN-2:0], 1'b1};
        end else begin
            r_next_s = trial_s[XLEN-1:0];
            q_next_s = {q_r[XLEN-2:0], 1'b0};
        end
    end

    // Sign correction; the quotient is never negated for a zero divisor so it stays all-ones.
    always_comb begin
        q_fix_s = neg_q_r ? (~q_r + {{(XLEN-1){1'b0}}, 1'b1}) : q_r;
        r_fix_s = neg_r_r ? (~r_r + {{(XLEN-1){1'b0}}, 1'b1}) : r_r;
        result  = rem_r ? r_fix_s : q_fix_s;
    end

    assign busy = (state_r == DIV_RUN);
    assign done = (state_r == DIV_DONE);

    // Divider FSM, iteration counter and datapath registers.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_r <= DIV_IDLE;
            count_r <= {CNT_W{1'b0}};
            q_r     <= {XLEN{1'b0}};
            r_r     <= {XLEN{1'b0}};
            d_r     <= {XLEN{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            rem_r   <= 1'b0;
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    if (start) begin
                        state_r <= DIV_RUN;
                        count_r <= {CNT_W{1'b0}};
                        q_r     <= mag_a_s;
                        r_r     <= {XLEN{1'b0}};
                        d_r     <= mag_b_s;
                        neg_q_r <= (sign_a_s ^ sign_b_s) && (divisor != {XLEN{1'b0}});
                        neg_r_r <= sign_a_s;
                        rem_r   <= is_rem;
                    end else begin
                        state_r <= DIV_IDLE;
                    end
                end
                DIV_RUN: begin
                    q_r     <= q_next_s;
                    r_r     <= r_next_s;
                    count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (count_r == CNT_W'(DIV_ITERS - 1)) begin
                        state_r <= DIV_DONE;
                    end else begin
                        state_r <= DIV_RUN;
                    end
                end
                DIV_DONE: begin
                    state_r <= DIV_IDLE;
                end
                default: begin
                    state_r <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: RV32IM execute stage.
//   Inputs : ID/EX operands (a_in, b_in, imm_in), mb_in, fs_in, control flags
//            (rw/md/mw, strb, rd), forwarding selects and sources, flush_in.
//   Outputs: stall_out (combinational) and the EX/MEM register: valid_out,
//            alu_out, store_data_out, rd_out, strb_out, rw/md/mw_out.
// Single-cycle ALU/multiply results register on the next edge; divides run in
// div_iter and hold the front of the pipeline until the DONE cycle.
module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int DIV_ITERS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic            mb_in,
    input  logic [3:0]      fs_in,
    input  logic            rw_in,
    input  logic            md_in,
    input  logic            mw_in,
    input  logic [3:0]      strb_in,
    input  logic [4:0]      rd_in,
    input  logic [1:0]      fwd_a_sel,
    input  logic [1:0]      fwd_b_sel,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic [XLEN-1:0] wb_fwd_data,
    input  logic            flush_in,
    output logic            stall_out,
    output logic            valid_out,
    output logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] store_data_out,
    output logic [4:0]      rd_out,
    output logic [3:0]      strb_out,
    output logic            rw_out,
    output logic            md_out,
    output logic            mw_out
);

    logic [XLEN-1:0]   op_a_s;
    logic [XLEN-1:0]   fwd_b_s;
    logic [XLEN-1:0]   op_b_s;
    logic [XLEN-1:0]   alu_s;
    logic [XLEN-1:0]   div_result_s;
    logic [2*XLEN-1:0] mul_full_s;
    logic [4:0]        shamt_s;
    logic              is_div_s;
    logic              div_start_s;
    logic              div_busy_s;
    logic              div_done_s;
    logic              stall_s;

    // Operand forwarding; reserved select code falls back to the ID/EX value.
    always_comb begin
        case (fwd_a_sel)
            FWD_ID:  op_a_s = a_in;
            FWD_MEM: op_a_s = mem_fwd_data;
            FWD_WB:  op_a_s = wb_fwd_data;
            default: op_a_s = a_in;
        endcase
        case (fwd_b_sel)
            FWD_ID:  fwd_b_s = b_in;
            FWD_MEM: fwd_b_s = mem_fwd_data;
            FWD_WB:  fwd_b_s = wb_fwd_data;
            default: fwd_b_s = b_in;
        endcase
        op_b_s  = mb_in ? imm_in : fwd_b_s;
        shamt_s = op_b_s[4:0];
    end

    // One sign-extended 64-bit product serves both MUL (low half) and MULH (high half).
    assign mul_full_s = $signed({{XLEN{op_a_s[XLEN-1]}}, op_a_s})
                      * $signed({{XLEN{op_b_s[XLEN-1]}}, op_b_s});

    // Single-cycle ALU.
    always_comb begin
        alu_s = {XLEN{1'b0}};
        case (fs_in)
            FS_ADD:  alu_s = op_a_s + op_b_s;
            FS_SUB:  alu_s = op_a_s - op_b_s;
            FS_SLL:  alu_s = op_a_s << shamt_s;
            FS_SLT:  alu_s = {{(XLEN-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
            FS_SLTU: alu_s = {{(XLEN-1){1'b0}}, (op_a_s < op_b_s)};
            FS_XOR:  alu_s = op_a_s ^ op_b_s;
            FS_SRL:  alu_s = op_a_s >> shamt_s;
            FS_SRA:  alu_s = $unsigned($signed(op_a_s) >>> shamt_s);
            FS_OR:   alu_s = op_a_s | op_b_s;
            FS_AND:  alu_s = op_a_s & op_b_s;
            FS_MUL:  alu_s = mul_full_s[XLEN-1:0];
            FS_MULH: alu_s = mul_full_s[2*XLEN-1:XLEN];
            default: alu_s = {XLEN{1'b0}};
        endcase
    end

    // Stall covers the latch cycle and every RUN cycle; flush or reset releases it at once.
    always_comb begin
        is_div_s    = is_div_op(fs_in);
        div_start_s = valid_in && is_div_s && !flush_in && !reset;
        stall_s     = !flush_in && !reset && (div_busy_s || (div_start_s && !div_done_s));
    end

    assign stall_out = stall_s;

    div_iter #(
        .XLEN      (XLEN),
        .DIV_ITERS (DIV_ITERS)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start_s),
        .flush     (flush_in),
        .is_signed (!fs_in[0]),
        .is_rem    (fs_in[1]),
        .dividend  (op_a_s),
        .divisor   (op_b_s),
        .busy      (div_busy_s),
        .done      (div_done_s),
        .result    (div_result_s)
    );

    // EX/MEM register. A divide op reaches the load branch only in its DONE cycle,
    // where ID/EX is still holding its control fields.
    always_ff @(posedge clk) begin
        if (reset || flush_in || stall_s || !valid_in) begin
            valid_out      <= 1'b0;
            alu_out        <= {XLEN{1'b0}};
            store_data_out <= {XLEN{1'b0}};
            rd_out         <= 5'd0;
            strb_out       <= 4'd0;
            rw_out         <= 1'b0;
            md_out         <= 1'b0;
            mw_out         <= 1'b0;
        end else begin
            valid_out      <= 1'b1;
            alu_out        <= is_div_s ? div_result_s : alu_s;
            store_data_out <= fwd_b_s;
            rd_out         <= rd_in;
            strb_out       <= strb_in;
            rw_out         <= rw_in;
            md_out         <= md_in;
            mw_out         <= mw_in;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed, table-driven bench for ex_stage plus hand-written
// sequences for divide latency, divide special cases, flush and reset.
module tb_ex_stage;
    import ex_pkg::*;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [31:0] a_in, b_in, imm_in;
    logic        mb_in;
    logic [3:0]  fs_in;
    logic        rw_in, md_in, mw_in;
    logic [3:0]  strb_in;
    logic [4:0]  rd_in;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        flush_in;
    logic        stall_out;
    logic        valid_out;
    logic [31:0] alu_out, store_data_out;
    logic [4:0]  rd_out;
    logic [3:0]  strb_out;
    logic        rw_out, md_out, mw_out;

    int n_checks = 0;
    int n_fail   = 0;

    ex_stage dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .a_in           (a_in),
        .b_in           (b_in),
        .imm_in         (imm_in),
        .mb_in          (mb_in),
        .fs_in          (fs_in),
        .rw_in          (rw_in),
        .md_in          (md_in),
        .mw_in          (mw_in),
        .strb_in        (strb_in),
        .rd_in          (rd_in),
        .fwd_a_sel      (fwd_a_sel),
        .fwd_b_sel      (fwd_b_sel),
        .mem_fwd_data   (mem_fwd_data),
        .wb_fwd_data    (wb_fwd_data),
        .flush_in       (flush_in),
        .stall_out      (stall_out),
        .valid_out      (valid_out),
        .alu_out        (alu_out),
        .store_data_out (store_data_out),
        .rd_out         (rd_out),
        .strb_out       (strb_out),
        .rw_out         (rw_out),
        .md_out         (md_out),
        .mw_out         (mw_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  fs;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        mb;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] mem;
        logic [31:0] wb;
        logic [31:0] exp_alu;
        logic [31:0] exp_sd;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0; a_in = 32'd0; b_in = 32'd0; imm_in = 32'd0; mb_in = 1'b0;
        fs_in = 4'd0; rw_in = 1'b0; md_in = 1'b0; mw_in = 1'b0; strb_in = 4'd0;
        rd_in = 5'd0; fwd_a_sel = 2'd0; fwd_b_sel = 2'd0;
        mem_fwd_data = 32'd0; wb_fwd_data = 32'd0; flush_in = 1'b0;
    endtask

    task automatic set_op(input logic [3:0] fs, input logic [31:0] a, input logic [31:0] b);
        valid_in = 1'b1; fs_in = fs; a_in = a; b_in = b; mb_in = 1'b0;
        fwd_a_sel = 2'd0; fwd_b_sel = 2'd0; rw_in = 1'b1; rd_in = 5'd9;
    endtask

    // Full divide: checks 33 stall cycles, bubble in DONE, result one cycle later.
    task automatic run_div(input logic [3:0] fs, input logic [31:0] a, input logic [31:0] b,
                           input logic use_mem, input logic [31:0] exp, input string nm);
        int cnt;
        set_op(fs, a, b);
        if (use_mem) begin
            fwd_a_sel = 2'd1; mem_fwd_data = a; a_in = 32'd0;
        end else begin
            mem_fwd_data = 32'd0;
        end
        #1;
        chk({nm, "_stall_first"}, {31'd0, stall_out}, 32'd1);
        cnt = 0;
        while (stall_out && cnt < 100) begin
            cnt++;
            @(posedge clk); #2;
            if (cnt == 1) mem_fwd_data = 32'd100;
        end
        chk({nm, "_stall_cycles"}, 32'(cnt), 32'd33);
        chk({nm, "_done_bubble"}, {31'd0, valid_out}, 32'd0);
        @(posedge clk); #2;
        chk({nm, "_result"}, alu_out, exp);
        chk({nm, "_valid"}, {31'd0, valid_out}, 32'd1);
        chk({nm, "_rd"}, {27'd0, rd_out}, 32'd9);
    endtask

    initial begin
        vecs[0]  = '{FS_ADD,  2'd1, 2'd0, 1'b0, 32'd99,        32'd7,         32'd0,    32'd5,    32'd0,   32'd12,        32'd7};
        vecs[1]  = '{FS_SUB,  2'd0, 2'd0, 1'b0, 32'd5,         32'd7,         32'd0,    32'd0,    32'd0,   32'hFFFFFFFE,  32'd7};
        vecs[2]  = '{FS_SLL,  2'd0, 2'd0, 1'b0, 32'd1,         32'd35,        32'd0,    32'd0,    32'd0,   32'd8,         32'd35};
        vecs[3]  = '{FS_SLT,  2'd0, 2'd0, 1'b0, 32'hFFFFFFFF,  32'd1,         32'd0,    32'd0,    32'd0,   32'd1,         32'd1};
        vecs[4]  = '{FS_SLTU, 2'd0, 2'd0, 1'b0, 32'hFFFFFFFF,  32'd1,         32'd0,    32'd0,    32'd0,   32'd0,         32'd1};
        vecs[5]  = '{FS_XOR,  2'd0, 2'd0, 1'b0, 32'hF0F0F0F0,  32'hFF00FF00,  32'd0,    32'd0,    32'd0,   32'h0FF00FF0,  32'hFF00FF00};
        vecs[6]  = '{FS_SRL,  2'd0, 2'd0, 1'b0, 32'h80000000,  32'd4,         32'd0,    32'd0,    32'd0,   32'h08000000,  32'd4};
        vecs[7]  = '{FS_SRA,  2'd0, 2'd0, 1'b0, 32'h80000000,  32'd4,         32'd0,    32'd0,    32'd0,   32'hF8000000,  32'd4};
        vecs[8]  = '{FS_OR,   2'd0, 2'd0, 1'b0, 32'h12340000,  32'h00005678,  32'd0,    32'd0,    32'd0,   32'h12345678,  32'h00005678};
        vecs[9]  = '{FS_AND,  2'd0, 2'd0, 1'b1, 32'h12345678,  32'hAAAA0000,  32'hFF,   32'd0,    32'd0,   32'h00000078,  32'hAAAA0000};
        vecs[10] = '{FS_MUL,  2'd0, 2'd0, 1'b0, 32'h00010000,  32'h00010001,  32'd0,    32'd0,    32'd0,   32'h00010000,  32'h00010001};
        vecs[11] = '{FS_MULH, 2'd0, 2'd0, 1'b0, 32'hFFFFFFFE,  32'd3,         32'd0,    32'd0,    32'd0,   32'hFFFFFFFF,  32'd3};
        vecs[12] = '{FS_ADD,  2'd0, 2'd2, 1'b0, 32'd1,         32'd50,        32'd0,    32'd0,    32'd100, 32'd101,       32'd100};
        vecs[13] = '{FS_ADD,  2'd3, 2'd0, 1'b0, 32'd3,         32'd4,         32'd0,    32'd1000, 32'd0,   32'd7,         32'd4};
        vecs[14] = '{FS_MULH, 2'd0, 2'd0, 1'b0, 32'h80000000,  32'h80000000,  32'd0,    32'd0,    32'd0,   32'h40000000,  32'h80000000};
        vecs[15] = '{FS_SUB,  2'd0, 2'd1, 1'b1, 32'd10,        32'd0,         32'd3,    32'd77,   32'd0,   32'd7,         32'd77};

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_alu",   alu_out, 32'd0);
        chk("reset_valid", {31'd0, valid_out}, 32'd0);
        chk("reset_ctl",   {20'd0, rd_out, rw_out, md_out, mw_out, strb_out}, 32'd0);
        chk("reset_stall", {31'd0, stall_out}, 32'd0);

        // Single-cycle table: control fields vary with the index.
        for (int i = 0; i < 16; i++) begin
            valid_in = 1'b1;
            fs_in = vecs[i].fs; fwd_a_sel = vecs[i].fa; fwd_b_sel = vecs[i].fb;
            mb_in = vecs[i].mb; a_in = vecs[i].a; b_in = vecs[i].b; imm_in = vecs[i].imm;
            mem_fwd_data = vecs[i].mem; wb_fwd_data = vecs[i].wb;
            rd_in = 5'(i + 1); rw_in = i[0]; md_in = i[1]; mw_in = ~i[0]; strb_in = 4'(i);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_alu", i), alu_out, vecs[i].exp_alu);
            chk($sformatf("vec%0d_store", i), store_data_out, vecs[i].exp_sd);
            chk($sformatf("vec%0d_valid", i), {31'd0, valid_out}, 32'd1);
            chk($sformatf("vec%0d_ctl", i), {20'd0, rd_out, rw_out, md_out, mw_out, strb_out},
                {20'd0, 5'(i + 1), i[0], i[1], ~i[0], 4'(i)});
        end
        idle_inputs();
        @(posedge clk); #1;
        chk("bubble_valid", {31'd0, valid_out}, 32'd0);

        // Divides, issued back to back.
        run_div(FS_DIV,  32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, "div_m7_2");
        run_div(FS_REM,  32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, "rem_m7_2");
        run_div(FS_DIVU, 32'd9,        32'd0,        1'b0, 32'hFFFFFFFF, "divu_9_0");
        run_div(FS_REM,  32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        "rem_ovf");
        run_div(FS_DIV,  32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, "div_ovf");
        run_div(FS_REMU, 32'd100,      32'd7,        1'b0, 32'd2,        "remu_100_7");
        run_div(FS_DIV,  32'hFFFFFFFB, 32'd0,        1'b0, 32'hFFFFFFFF, "div_m5_0");
        run_div(FS_REM,  32'hFFFFFFFB, 32'd0,        1'b0, 32'hFFFFFFFB, "rem_m5_0");
        idle_inputs();
        @(posedge clk); #1;

        // Flush in cycle N+10 of a divide.
        set_op(FS_DIV, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        chk("flush_pre_stall", {31'd0, stall_out}, 32'd1);
        flush_in = 1'b1;
        #1;
        chk("flush_stall_drop", {31'd0, stall_out}, 32'd0);
        @(posedge clk); #1;
        flush_in = 1'b0; valid_in = 1'b0;
        #1;
        chk("flush_bubble", {31'd0, valid_out}, 32'd0);
        chk("flush_idle_stall", {31'd0, stall_out}, 32'd0);
        set_op(FS_ADD, 32'd2, 32'd3);
        @(posedge clk); #1;
        chk("post_flush_add", alu_out, 32'd5);
        chk("post_flush_valid", {31'd0, valid_out}, 32'd1);

        // Reset while a valid result is being loaded.
        set_op(FS_ADD, 32'd20, 32'd22);
        @(posedge clk); #1;
        chk("pre_reset_add", alu_out, 32'd42);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("reset_add_alu", alu_out, 32'd0);
        chk("reset_add_ctl", {20'd0, rd_out, rw_out, md_out, mw_out, strb_out}, 32'd0);

        // Reset mid-divide.
        set_op(FS_DIVU, 32'd50, 32'd5);
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_div_stall", {31'd0, stall_out}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; valid_in = 1'b0;
        #1;
        chk("reset_div_stall", {31'd0, stall_out}, 32'd0);
        chk("reset_div_valid", {31'd0, valid_out}, 32'd0);
        chk("reset_div_alu", alu_out, 32'd0);
        set_op(FS_ADD, 32'd2, 32'd3);
        @(posedge clk); #1;
        chk("post_reset_add", alu_out, 32'd5);
        chk("post_reset_valid", {31'd0, valid_out}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
